// File: rtl/systolic_mm_stream.sv
// rtl/systolic_mm_stream.sv - output-stationary signed systolic matmul C = W*D with skewed operand streaming and row drain.
// Define SYSTOLIC_MM_SATURATE_EN to saturate each result element to OUT_WIDTH instead of wrapping.
module systolic_mm_stream #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int OUT_WIDTH  = 32,
  parameter int K_WIDTH    = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [K_WIDTH-1:0]                k_len,
  output logic                              busy,
  output logic                              done,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]  w_col,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]  d_row,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ARRAY_SIZE*OUT_WIDTH-1:0]   out_row,
  output logic [$clog2(ARRAY_SIZE)-1:0]     out_row_idx,
  output logic                              out_last
);
  localparam int N  = ARRAY_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int OW = OUT_WIDTH;
  localparam int RW = $clog2(N);
  localparam int FW = $clog2(2 * N);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [K_WIDTH-1:0]  k_q, k_d, beat_q, beat_d;
  logic [FW-1:0]       flush_q, flush_d;
  logic [RW-1:0]       row_q, row_d;
  logic                done_q, done_d;
  logic                clear, advance, load_en;

  logic signed [DW-1:0]   a_inj  [N];
  logic signed [DW-1:0]   b_inj  [N];
  logic signed [DW-1:0]   a_skew [N];
  logic signed [DW-1:0]   b_skew [N];
  logic signed [DW-1:0]   a_sk_q [N][N-1];
  logic signed [DW-1:0]   b_sk_q [N][N-1];
  logic signed [DW-1:0]   a_q    [N][N];
  logic signed [DW-1:0]   b_q    [N][N];
  logic signed [DW-1:0]   a_in   [N][N];
  logic signed [DW-1:0]   b_in   [N][N];
  logic signed [2*DW-1:0] prod   [N][N];
  logic signed [AW-1:0]   acc_q  [N][N];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    row_d   = row_q;
    done_d  = 1'b0;
    clear   = 1'b0;
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          clear   = 1'b1;
          k_d     = k_len;
          beat_d  = '0;
          flush_d = '0;
          row_d   = '0;
          state_d = (k_len == '0) ? S_DRAIN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          advance = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == k_q - 1'b1) begin
            state_d = S_FLUSH;
            flush_d = '0;
          end
        end
      end
      S_FLUSH: begin
        // 2N-1 zero beats push the last operand through to PE(N-1,N-1)
        advance = 1'b1;
        flush_d = flush_q + 1'b1;
        if (flush_q == FW'(2 * N - 2)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (row_q == RW'(N - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            row_d   = '0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  assign load_en = (state_q == S_LOAD);

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign a_inj[gi] = load_en ? $signed(w_col[gi*DW +: DW]) : '0;
    assign b_inj[gi] = load_en ? $signed(d_row[gi*DW +: DW]) : '0;
    if (gi == 0) begin : g_noskew
      assign a_skew[gi] = a_inj[gi];
      assign b_skew[gi] = b_inj[gi];
    end else begin : g_skew
      assign a_skew[gi] = a_sk_q[gi][gi-1];
      assign b_skew[gi] = b_sk_q[gi][gi-1];
    end
    for (genvar gj = 0; gj < N; gj++) begin : g_pe
      if (gj == 0) begin : g_aw
        assign a_in[gi][gj] = a_skew[gi];
      end else begin : g_ai
        assign a_in[gi][gj] = a_q[gi][gj-1];
      end
      if (gi == 0) begin : g_bn
        assign b_in[gi][gj] = b_skew[gj];
      end else begin : g_bi
        assign b_in[gi][gj] = b_q[gi-1][gj];
      end
      assign prod[gi][gj] = a_in[gi][gj] * b_in[gi][gj];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int i = 0; i < N; i++) begin
        for (int s = 0; s < N - 1; s++) begin
          a_sk_q[i][s] <= '0;
          b_sk_q[i][s] <= '0;
        end
        for (int j = 0; j < N; j++) begin
          a_q[i][j]   <= '0;
          b_q[i][j]   <= '0;
          acc_q[i][j] <= '0;
        end
      end
    end else if (advance) begin
      for (int i = 0; i < N; i++) begin
        a_sk_q[i][0] <= a_inj[i];
        b_sk_q[i][0] <= b_inj[i];
        for (int s = 1; s < N - 1; s++) begin
          if (s < i) begin
            a_sk_q[i][s] <= a_sk_q[i][s-1];
            b_sk_q[i][s] <= b_sk_q[i][s-1];
          end
        end
        for (int j = 0; j < N; j++) begin
          a_q[i][j]   <= a_in[i][j];
          b_q[i][j]   <= b_in[i][j];
          acc_q[i][j] <= acc_q[i][j] + AW'(prod[i][j]);
        end
      end
    end
  end

`ifdef SYSTOLIC_MM_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic [OW-1:0] conv(input logic signed [AW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[OW-1:0];
    if (v < SAT_MIN) return SAT_MIN[OW-1:0];
    return v[OW-1:0];
  endfunction
`else
  function automatic logic [OW-1:0] conv(input logic signed [AW-1:0] v);
    return v[OW-1:0];
  endfunction
`endif

  always_comb begin
    out_row = '0;
    if (out_valid) begin
      for (int j = 0; j < N; j++) out_row[j*OW +: OW] = conv(acc_q[row_q][j]);
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign in_ready    = load_en;
  assign out_valid   = (state_q == S_DRAIN);
  assign out_last    = out_valid && (row_q == RW'(N - 1));
  assign out_row_idx = row_q;
  assign done        = done_q;
endmodule

// File: tb/tb_systolic_mm_stream.sv
// tb/tb_systolic_mm_stream.sv - directed vector bench for systolic_mm_stream at ARRAY_SIZE=4.
module tb_systolic_mm_stream;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int OW = 32;
  localparam int KW = 10;
`ifdef SYSTOLIC_MM_SATURATE_EN
  localparam int EXT = 2147483647;
`else
  localparam int EXT = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic            busy, done, in_ready, out_valid, out_last;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [N*DW-1:0] w_col = '0;
  logic [N*DW-1:0] d_row = '0;
  logic [N*OW-1:0] out_row;
  logic [1:0]      out_row_idx;

  int n_cmp = 0;
  int n_bad = 0;

  systolic_mm_stream #(.ARRAY_SIZE(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .w_col(w_col), .d_row(d_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 kind;
    int                 k;
    bit                 gap_in;
    bit                 gap_out;
    bit                 spam;
    logic [4*N*OW-1:0]  exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] w_val(input int kind, input int i, input int k);
    case (kind)
      0:       return (i == k) ? 16'd1 : 16'd0;
      1:       return 16'h8000;
      2:       return 16'd2;
      default: return (k == 0) ? 16'(i + 1) : 16'hFFFF;
    endcase
  endfunction

  function automatic logic [DW-1:0] d_val(input int kind, input int k, input int j);
    case (kind)
      0:       return 16'(10 * k + j);
      1:       return 16'h8000;
      2:       return 16'd2;
      default: return (k == 0) ? 16'(j) : 16'd3;
    endcase
  endfunction

  function automatic logic [N*OW-1:0] row4(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  function automatic logic [4*N*OW-1:0] all4(input int v);
    return {4{row4(v, v, v, v)}};
  endfunction

  task automatic drive_beat(input int kind, input int beat, input int k);
    for (int i = 0; i < N; i++) begin
      w_col[i*DW +: DW] = (beat < k) ? w_val(kind, i, beat) : 16'd7;
      d_row[i*DW +: DW] = (beat < k) ? d_val(kind, beat, i) : 16'd7;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " busy"}, 128'(busy), 128'(0));
    chk({tag, " done"}, 128'(done), 128'(0));
    chk({tag, " in_ready"}, 128'(in_ready), 128'(0));
    chk({tag, " out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, " out_last"}, 128'(out_last), 128'(0));
    chk({tag, " out_row_idx"}, 128'(out_row_idx), 128'(0));
    chk({tag, " out_row"}, out_row, 128'(0));
  endtask

  task automatic run_job(input int id, input vec_t v);
    int cyc = 0, beat = 0, row = 0, dones = 0, hold = 0, post = 0;
    int first_v = -1, done_c = -1;
    bit prev_stall = 0;
    logic [N*OW-1:0] prev_row = '0;
    @(negedge clk);
    start = 1'b1; k_len = KW'(v.k); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (cyc < 300 && post < 4) begin
      @(negedge clk);
      cyc++;
      if (out_valid && first_v < 0) first_v = cyc;
      if (prev_stall) chk($sformatf("v%0d row_stable c%0d", id, cyc), out_row, prev_row);
      if (dones > 0) post++;
      if (done) begin
        dones++;
        if (done_c < 0) done_c = cyc;
        chk($sformatf("v%0d busy_at_done", id), 128'(busy), 128'(0));
      end
      in_valid = v.gap_in ? (cyc % 3 == 1) : 1'b1;
      drive_beat(v.kind, beat, v.k);
      if (v.gap_out && out_valid && hold < 5) begin
        out_ready = 1'b0;
        hold++;
      end else begin
        out_ready = 1'b1;
      end
      start = v.spam && busy && (cyc % 4 == 2);
      if (in_ready && in_valid) beat++;
      if (out_valid && out_ready) begin
        chk($sformatf("v%0d row_idx r%0d", id, row), 128'(out_row_idx), 128'(row));
        chk($sformatf("v%0d out_last r%0d", id, row), 128'(out_last), 128'(row == N - 1));
        chk($sformatf("v%0d out_row r%0d", id, row), out_row, v.exp[row*N*OW +: N*OW]);
        row++;
      end
      prev_stall = out_valid && !out_ready;
      prev_row   = out_row;
    end
    if (cyc >= 300) $display("FAIL v%0d timeout: got %0d cycles required done within 300", id, cyc);
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
    chk($sformatf("v%0d rows", id), 128'(row), 128'(N));
    chk($sformatf("v%0d done_count", id), 128'(dones), 128'(1));
    chk($sformatf("v%0d beats", id), 128'(beat), 128'(v.k));
    chk($sformatf("v%0d idle_after", id), 128'(busy), 128'(0));
    if (!v.gap_in && !v.gap_out) begin
      chk($sformatf("v%0d first_valid_cyc", id), 128'(first_v), 128'((v.k == 0) ? 1 : v.k + 2 * N));
      chk($sformatf("v%0d done_cyc", id), 128'(done_c), 128'(first_v + N));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int beats;
    vecs[0] = '{0, 4, 0, 0, 0, {row4(30, 31, 32, 33), row4(20, 21, 22, 23), row4(10, 11, 12, 13), row4(0, 1, 2, 3)}};
    vecs[1] = '{0, 4, 1, 1, 0, {row4(30, 31, 32, 33), row4(20, 21, 22, 23), row4(10, 11, 12, 13), row4(0, 1, 2, 3)}};
    vecs[2] = '{1, 4, 0, 0, 0, all4(EXT)};
    vecs[3] = '{0, 0, 0, 0, 0, all4(0)};
    vecs[4] = '{3, 2, 0, 0, 1, {row4(-3, 1, 5, 9), row4(-3, 0, 3, 6), row4(-3, -1, 1, 3), row4(-3, -2, -1, 0)}};
    vecs[5] = '{2, 1, 0, 0, 0, all4(4)};

    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) run_job(v, vecs[v]);

    // abort a job as its third beat is presented
    @(negedge clk);
    start = 1'b1; k_len = KW'(4); in_valid = 1'b1; drive_beat(0, 0, 4);
    @(posedge clk);
    #1 start = 1'b0;
    beats = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (beats == 2) begin
        rst_n = 1'b0;
        break;
      end
      drive_beat(0, beats, 4);
      if (in_ready && in_valid) beats++;
    end
    chk("mid_reset beats", 128'(beats), 128'(2));
    @(negedge clk);
    chk_reset("mid_reset");
    rst_n = 1'b1; in_valid = 1'b0;
    run_job(5, vecs[5]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/systolic_mm_stream.md
# systolic_mm_stream

Parametrised, output-stationary signed systolic matrix multiplier with start/busy/done control, valid/ready operand streaming, internal operand skewing and a row-serial result drain. It computes C[ARRAY_SIZE×ARRAY_SIZE] = W·D over a runtime depth k_len. It sits between the TPU operand SRAM readers and the result writeback path. It replaces fixed-size arrays that need an external cycle counter and a result-diagonal index.

## Interface
- ARRAY_SIZE, 8, rows = columns of the PE grid (≥2)
- DATA_WIDTH, 16, signed operand width
- ACC_WIDTH, 40, signed accumulator width (≥ 2*DATA_WIDTH)
- OUT_WIDTH, 32, signed result element width (≤ ACC_WIDTH)
- K_WIDTH, 10, width of k_len

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin job; sampled only in IDLE
- k_len  in  K_WIDTH  reduction depth, captured with start
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job completion
- in_valid  in  1  operand beat valid
- in_ready  out  1  array accepts operand beat
- w_col  in  ARRAY_SIZE*DATA_WIDTH  W[:,k]; lane i at bits i*DATA_WIDTH, feeds row i
- d_row  in  ARRAY_SIZE*DATA_WIDTH  D[k,:]; lane j at bits j*DATA_WIDTH, feeds column j
- out_valid  out  1  result row valid
- out_ready  in  1  downstream accepts row
- out_row  out  ARRAY_SIZE*OUT_WIDTH  C[r,:]; column j at bits j*OUT_WIDTH
- out_row_idx  out  $clog2(ARRAY_SIZE)  r of current row
- out_last  out  1  out_valid and r == ARRAY_SIZE-1

## Operation
- FSM: IDLE → LOAD → FLUSH → DRAIN → IDLE.
- IDLE: on start, capture k_len, clear all accumulators and skew registers, and set the beat count to 0. Go to LOAD, or to DRAIN directly when k_len == 0.
- LOAD: in_ready = 1. Each in_valid && in_ready is one advance. After beat k_len-1 is accepted, go to FLUSH.
- FLUSH: lasts exactly 2*ARRAY_SIZE-1 cycles. Each cycle is an advance with zero operands injected. Then go to DRAIN.
- Advance:
  - Row-lane i passes through an i-stage skew shift register; column-lane j passes through a j-stage skew shift register.
  - Every PE(i,j) does acc += a*b. It forwards a to the right and b downward through a register.
  - All skew and PE registers hold when there is no advance.
- Arithmetic:
  - Product is signed 2*DATA_WIDTH, sign-extended to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH.
- DRAIN:
  - out_valid = 1 and out_row presents row r, starting at r = 0.
  - r increments on out_valid && out_ready.
  - On the handshake with r = ARRAY_SIZE-1, go to IDLE and pulse done for one cycle.
- Output conversion:
  - The default result is the low OUT_WIDTH bits of acc (see Configuration).
  - out_row is stable while out_valid && !out_ready.
- start asserted while busy is ignored. in_valid outside LOAD is ignored.
- k_len == 0: result rows are all zero.

## Timing
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_last=0, out_row_idx=0, out_row=0. State is IDLE. Accumulators and skew registers are 0.
- Reset mid-job aborts immediately. No done pulse is generated and no partial row is emitted.
- start is accepted in cycle T. busy=1 and in_ready=1 from T+1.
- With in_valid held high and k_len=K, the last beat is accepted at T+K. The first out_valid is at T+K+2*ARRAY_SIZE.
- With out_ready held high, rows are emitted one per cycle. done is high in the cycle after the last row handshake, and busy=0 in that same cycle.
- in_valid gaps during LOAD stall the array without corrupting results.
- out_ready low holds DRAIN indefinitely.

## Configuration
- SYSTOLIC_MM_SATURATE_EN defined: each output element saturates acc to the signed OUT_WIDTH range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Macro undefined: each output element is the low OUT_WIDTH bits of acc (two's-complement wrap).
- Accumulator behaviour is identical in both builds.

## Test plan
- All tests use ARRAY_SIZE=4 and DATA_WIDTH=16 with the other parameters at default.
- Identity: W=I, D[k][j]=10k+j, K=4, continuous valid/ready → out_row r = {10r+0, 10r+1, 10r+2, 10r+3}; first out_valid at T+12; done at T+16.
- Stall: same data with in_valid toggling 1,0,0,1,… and out_ready low for 5 cycles during DRAIN → identical rows; out_row stable while stalled.
- Signed extremes: W=D=-32768 everywhere, K=4 → every C element = 4*2^30 = 2^32. Macro off → 0. Macro on → 2147483647.
- k_len=0 → busy for 4 DRAIN cycles, all-zero rows, out_last on row 3, done pulse.
- Reset at the 3rd LOAD beat → all outputs at reset values next cycle. A new job with K=1, W=D=all 2 → every element = 4.
- start pulses during LOAD and DRAIN → ignored; exactly one done per accepted start.
